demux_1to4_buf: RTL and testbench

DEMUX_1TO4_BUF -- requirements
Module: demux_1to4_buf

---
 rtl/demux_1to4_buf.sv | 96 +++++++++
 tb/tb_demux_1to4_buf.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to4_buf.sv
// demux_1to4_buf
//   Routes a valid/ready input stream to one of four buffered output
//   channels. Each channel holds one word in an output register, so an
//   accepted word appears on its channel one cycle after the accept.
//   AUTO=0 picks the channel from {s1,s0}. AUTO=1 picks it round-robin
//   from rr_ptr, which advances only when a word is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all channels and counters
//   in_data    upstream word, WIDTH bits
//   in_valid   upstream word present
//   in_ready   target channel is empty, or is being drained this cycle
//   s0, s1     channel select {s1,s0}; used only when AUTO=0
//   out_data   channel k word at [k*WIDTH +: WIDTH]
//   out_valid  bit k set while channel k holds a word
//   out_ready  bit k set when the channel k consumer takes its word
//   rr_ptr     current round-robin target; stays 0 when AUTO=0
//   xfer_cnt   number of accepted words, wraps at 16 bits
module demux_1to4_buf #(
  parameter int WIDTH = 8,
  parameter bit AUTO  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               s0,
  input  logic               s1,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [1:0]         rr_ptr,
  output logic [15:0]        xfer_cnt
);

  logic [3:0]       valid_q, valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [15:0]      xfer_cnt_q, xfer_cnt_d;
  logic [1:0]       tgt;
  logic             accept;

  assign tgt = AUTO ? rr_ptr_q : {s1, s0};

  // A full channel that is being drained this same edge can take the new
  // word, which is what sustains one word per cycle through a channel.
  // In reset all valid flags are clear, so in_ready reads 1 there too.
  assign in_ready = ~valid_q[tgt] | out_ready[tgt];
  assign accept   = in_valid & in_ready;

  always_comb begin
    // Drained channels clear; a load on the same edge overrides the clear.
    valid_d    = valid_q & ~out_ready;
    data_d     = data_q;
    rr_ptr_d   = rr_ptr_q;
    xfer_cnt_d = xfer_cnt_q;
    if (accept) begin
      valid_d[tgt] = 1'b1;
      data_d[tgt]  = in_data;
      xfer_cnt_d   = xfer_cnt_q + 16'd1;
      if (AUTO) begin
        rr_ptr_d = rr_ptr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 4'b0000;
      rr_ptr_q   <= 2'd0;
      xfer_cnt_q <= 16'd0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      rr_ptr_q   <= rr_ptr_d;
      xfer_cnt_q <= xfer_cnt_d;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_pack
    assign out_data[k*WIDTH +: WIDTH] = data_q[k];
  end

  assign out_valid = valid_q;
  assign rr_ptr    = rr_ptr_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Bench for demux_1to4_buf: one instance with select-driven routing and one
// with round-robin routing share all inputs. A channel-slot model of each is
// compared on every falling edge; directed scenarios add literal checks.
module tb_demux_1to4_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        s0, s1;
  logic [3:0]  out_ready;

  logic        rdy0, rdy1;
  logic [31:0] od0, od1;
  logic [3:0]  ov0, ov1;
  logic [1:0]  rp0, rp1;
  logic [15:0] xc0, xc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  demux_1to4_buf #(.WIDTH(8), .AUTO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy0), .s0(s0), .s1(s1), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .rr_ptr(rp0), .xfer_cnt(xc0)
  );

  demux_1to4_buf #(.WIDTH(8), .AUTO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy1), .s0(s0), .s1(s1), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .rr_ptr(rp1), .xfer_cnt(xc1)
  );

  // Model: per channel a "holds a word" flag and the word itself, plus the
  // round-robin pointer and the accept count.
  typedef struct packed {
    logic [3:0]      v;
    logic [3:0][7:0] d;
    logic [1:0]      p;
    logic [15:0]     c;
  } model_t;

  model_t m0, m1;

  function automatic logic [1:0] mtarget(model_t m, bit a);
    return a ? m.p : {s1, s0};
  endfunction

  function automatic logic mready(model_t m, bit a);
    logic [1:0] t;
    t = mtarget(m, a);
    return (m.v[t] == 1'b0) || (out_ready[t] == 1'b1);
  endfunction

  function automatic model_t mnext(model_t m, bit a);
    model_t     n;
    logic [1:0] t;
    n = m;
    t = mtarget(m, a);
    for (int k = 0; k < 4; k++) begin
      if (m.v[k] && out_ready[k]) n.v[k] = 1'b0;
    end
    if (in_valid && mready(m, a)) begin
      n.v[t] = 1'b1;
      n.d[t] = in_data;
      n.c    = m.c + 16'd1;
      if (a) n.p = m.p + 2'd1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mnext(m0, 1'b0);
      m1 <= mnext(m1, 1'b1);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("d0.out_valid", ov0, m0.v);
      chk("d0.out_data",  od0, m0.d);
      chk("d0.rr_ptr",    rp0, m0.p);
      chk("d0.xfer_cnt",  xc0, m0.c);
      chk("d0.in_ready",  rdy0, mready(m0, 1'b0));
      chk("d1.out_valid", ov1, m1.v);
      chk("d1.out_data",  od1, m1.d);
      chk("d1.rr_ptr",    rp1, m1.p);
      chk("d1.xfer_cnt",  xc1, m1.c);
      chk("d1.in_ready",  rdy1, mready(m1, 1'b1));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    s0        = 1'b0;
    s1        = 1'b0;
    out_ready = 4'b0000;
    #1;
    chk("reset.out_valid", ov0, 4'b0000);
    chk("reset.out_data",  od0, 32'h0);
    chk("reset.xfer_cnt",  xc1, 16'h0);
    chk("reset.in_ready",  rdy0, 1'b1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Select-routed word to channel 2, consumer stalled
    {s1, s0} = 2'b10; in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sel.valid", ov0, 4'b0100);
    chk("sel.data2", od0[23:16], 8'hA5);
    chk("sel.cnt",   xc0, 16'd1);
    step();
    chk("sel.hold", od0[23:16], 8'hA5);

    // Second word blocked, then drain and load on one edge
    in_data = 8'h3C; in_valid = 1'b1;
    #1;
    chk("block.in_ready", rdy0, 1'b0);
    step();
    chk("block.cnt",  xc0, 16'd1);
    chk("block.data", od0[23:16], 8'hA5);
    out_ready = 4'b0100;
    #1;
    chk("drain.in_ready", rdy0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("drain.data2", od0[23:16], 8'h3C);
    chk("drain.valid", ov0[2], 1'b1);
    chk("drain.cnt",   xc0, 16'd2);
    step();

    // Round-robin, back-to-back words with every consumer ready
    do_reset();
    out_ready = 4'b1111;
    for (int w = 1; w <= 6; w++) begin
      in_data = 8'(w); in_valid = 1'b1;
      #1;
      chk("rr.in_ready", rdy1, 1'b1);
      step();
      if (w == 4) chk("rr.ch3", od1[31:24], 8'd4);
    end
    in_valid = 1'b0;
    chk("rr.valid", ov1, 4'b0010);
    chk("rr.ch1",   od1[15:8], 8'd6);
    chk("rr.ch0",   od1[7:0], 8'd5);
    chk("rr.ptr",   rp1, 2'd2);
    chk("rr.cnt",   xc1, 16'd6);
    step();

    // Round-robin stalls on full channel 1 instead of skipping
    do_reset();
    out_ready = 4'b1101;
    for (int w = 0; w < 5; w++) begin
      in_data = 8'h10 + 8'(w); in_valid = 1'b1;
      step();
    end
    chk("stall.ptr0", rp1, 2'd1);
    chk("stall.full", ov1[1], 1'b1);
    in_data = 8'h15;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.in_ready", rdy1, 1'b0);
      step();
      chk("stall.ptr",  rp1, 2'd1);
      chk("stall.ch1",  od1[15:8], 8'h11);
    end
    out_ready = 4'b1111;
    #1;
    chk("unstall.in_ready", rdy1, 1'b1);
    step();
    in_valid = 1'b0;
    chk("unstall.ptr", rp1, 2'd2);
    chk("unstall.ch1", od1[15:8], 8'h15);
    chk("unstall.cnt", xc1, 16'd6);
    step();

    // Asynchronous reset mid-cycle with channels 0 and 3 full
    do_reset();
    out_ready = 4'b0000;
    {s1, s0} = 2'b00; in_data = 8'h77; in_valid = 1'b1;
    step();
    {s1, s0} = 2'b11; in_data = 8'h88;
    step();
    in_valid = 1'b0;
    chk("pre_rst.valid", ov0, 4'b1001);
    rst_n = 1'b0;
    #1;
    chk("arst.valid0", ov0, 4'b0000);
    chk("arst.data0",  od0, 32'h0);
    chk("arst.cnt0",   xc0, 16'h0);
    chk("arst.valid1", ov1, 4'b0000);
    chk("arst.data1",  od1, 32'h0);
    chk("arst.ptr1",   rp1, 2'd0);
    chk("arst.cnt1",   xc1, 16'h0);
    in_valid = 1'b1;
    #1;
    chk("arst.in_ready0", rdy0, 1'b1);
    chk("arst.in_ready1", rdy1, 1'b1);
    step();
    chk("arst.no_accept", ov0, 4'b0000);
    chk("arst.no_cnt",    xc0, 16'h0);
    rst_n = 1'b1;
    {s1, s0} = 2'b01; in_data = 8'h5A;
    step();
    in_valid = 1'b0;
    chk("post_rst.valid", ov0, 4'b0010);
    chk("post_rst.data",  od0[15:8], 8'h5A);
    chk("post_rst.cnt",   xc0, 16'd1);
    step();

    // Accept counter wraps after 65536 accepts
    do_reset();
    out_ready = 4'b1111;
    {s1, s0} = 2'b00; in_data = 8'hC3; in_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #2;
    chk("wrap.max", xc0, 16'hFFFF);
    step();
    in_valid = 1'b0;
    chk("wrap.cnt0", xc0, 16'h0);
    chk("wrap.cnt1", xc1, 16'h0);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
